// File: rtl/window_scan_fsm.sv
// Frame scan sequencer: NUM_WIN windows x LINES_PER_WIN lines x DATA_PER_LINE beats.
// Optional stall counter enabled by defining WINDOW_SCAN_STALL_CNT_EN.
module window_scan_fsm #(
    parameter int unsigned DATA_PER_LINE = 64,
    parameter int unsigned LINES_PER_WIN = 16,
    parameter int unsigned NUM_WIN       = 4,
    localparam int unsigned DW = (DATA_PER_LINE > 1) ? $clog2(DATA_PER_LINE) : 1,
    localparam int unsigned LW = (LINES_PER_WIN > 1) ? $clog2(LINES_PER_WIN) : 1,
    localparam int unsigned WW = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [2:0]    state,
    output logic [DW-1:0] count_data,
    output logic [LW-1:0] count_line,
    output logic [WW-1:0] count_wind,
    output logic          line_end,
    output logic          win_end,
    output logic          frame_done,
    output logic          busy,
    output logic [15:0]   stall_cnt
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_DATA = 3'd1;
    localparam logic [2:0] S_LINE = 3'd2;
    localparam logic [2:0] S_WIN  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [DW-1:0] LAST_DATA = DW'(DATA_PER_LINE - 1);
    localparam logic [LW-1:0] LAST_LINE = LW'(LINES_PER_WIN - 1);
    localparam logic [WW-1:0] LAST_WIN  = WW'(NUM_WIN - 1);

    logic [2:0]    state_q, state_d;
    logic [DW-1:0] cnt_d_q, cnt_d_d;
    logic [LW-1:0] cnt_l_q, cnt_l_d;
    logic [WW-1:0] cnt_w_q, cnt_w_d;
`ifdef WINDOW_SCAN_STALL_CNT_EN
    logic [15:0]   stall_q, stall_d;
`endif

    // State and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_d_q <= '0;
            cnt_l_q <= '0;
            cnt_w_q <= '0;
`ifdef WINDOW_SCAN_STALL_CNT_EN
            stall_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_d_q <= cnt_d_d;
            cnt_l_q <= cnt_l_d;
            cnt_w_q <= cnt_w_d;
`ifdef WINDOW_SCAN_STALL_CNT_EN
            stall_q <= stall_d;
`endif
        end
    end

    // Next state and counter updates; abort overrides everything
    always_comb begin
        state_d = state_q;
        cnt_d_d = cnt_d_q;
        cnt_l_d = cnt_l_q;
        cnt_w_d = cnt_w_q;
`ifdef WINDOW_SCAN_STALL_CNT_EN
        stall_d = stall_q;
`endif
        if (abort) begin
            state_d = S_IDLE;
            cnt_d_d = '0;
            cnt_l_d = '0;
            cnt_w_d = '0;
`ifdef WINDOW_SCAN_STALL_CNT_EN
            stall_d = '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_DATA;
                        cnt_d_d = '0;
                        cnt_l_d = '0;
                        cnt_w_d = '0;
`ifdef WINDOW_SCAN_STALL_CNT_EN
                        stall_d = '0;
`endif
                    end
                end
                S_DATA: begin
                    if (in_valid) begin
                        if (cnt_d_q == LAST_DATA) begin
                            cnt_d_d = '0;
                            state_d = S_LINE;
                        end else begin
                            cnt_d_d = cnt_d_q + DW'(1);
                        end
                    end else begin
`ifdef WINDOW_SCAN_STALL_CNT_EN
                        if (stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
`endif
                    end
                end
                S_LINE: begin
                    if (cnt_l_q == LAST_LINE) begin
                        cnt_l_d = '0;
                        state_d = S_WIN;
                    end else begin
                        cnt_l_d = cnt_l_q + LW'(1);
                        state_d = S_DATA;
                    end
                end
                S_WIN: begin
                    if (cnt_w_q == LAST_WIN) begin
                        cnt_w_d = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_w_d = cnt_w_q + WW'(1);
                        state_d = S_DATA;
                    end
                end
                S_DONE: state_d = S_IDLE;
                default: begin
                    state_d = S_IDLE;
                    cnt_d_d = '0;
                    cnt_l_d = '0;
                    cnt_w_d = '0;
                end
            endcase
        end
    end

    // Output decodes of registered state only
    always_comb begin
        state      = state_q;
        count_data = cnt_d_q;
        count_line = cnt_l_q;
        count_wind = cnt_w_q;
        in_ready   = (state_q == S_DATA);
        line_end   = (state_q == S_LINE);
        win_end    = (state_q == S_WIN);
        frame_done = (state_q == S_DONE);
        busy       = (state_q != S_IDLE);
`ifdef WINDOW_SCAN_STALL_CNT_EN
        stall_cnt  = stall_q;
`else
        stall_cnt  = 16'h0000;
`endif
    end

endmodule

// File: tb/tb_window_scan_fsm.sv
// Directed bench for window_scan_fsm with a 4-beat x 2-line x 2-window frame.
module tb_window_scan_fsm;

    logic        clk = 1'b0;
    logic        reset, start, abort, in_valid;
    logic        in_ready, line_end, win_end, frame_done, busy;
    logic [2:0]  state;
    logic [1:0]  count_data;
    logic [0:0]  count_line;
    logic [0:0]  count_wind;
    logic [15:0] stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    window_scan_fsm #(.DATA_PER_LINE(4), .LINES_PER_WIN(2), .NUM_WIN(2)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .in_valid(in_valid),
        .in_ready(in_ready), .state(state), .count_data(count_data),
        .count_line(count_line), .count_wind(count_wind), .line_end(line_end),
        .win_end(win_end), .frame_done(frame_done), .busy(busy), .stall_cnt(stall_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_state"}, 32'(state), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_ready"}, 32'(in_ready), 32'd0);
        check_eq({tag, "_cnts"}, 32'({count_data, count_line, count_wind}), 32'd0);
        check_eq({tag, "_strobes"}, 32'({line_end, win_end, frame_done}), 32'd0);
    endtask

    // mode 0: valid held high; 1: valid toggles 0,1 per DATA cycle; 2: start poked in DATA/LINE
    task automatic run_frame(input int mode, output int ncyc, output int nline, output int nwin,
                             output int ndone, output logic [15:0] stall_done, output bit ok);
        bit phase = 1'b0;
        ok = 1'b0; ncyc = 0; nline = 0; nwin = 0; ndone = 0; stall_done = '0;
        start = 1'b1;
        in_valid = (mode != 1);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            ncyc++;
            if (line_end) nline++;
            if (win_end) nwin++;
            if (frame_done) begin
                ndone++;
                stall_done = stall_cnt;
                ok = 1'b1;
            end
            if (mode == 1) begin
                in_valid = (state == 3'd1) ? phase : 1'b0;
                if (state == 3'd1) phase = ~phase;
            end else begin
                in_valid = 1'b1;
            end
            start = (mode == 2) && (state == 3'd1 || state == 3'd2);
            @(negedge clk);
        end
        start = 1'b0;
        in_valid = 1'b0;
        if (!ok) $display("FAIL frame_timeout: got no DONE, expected DONE within 200 cycles");
    endtask

    int ncyc, nline, nwin, ndone;
    logic [15:0] stall_done;
    bit ok, found;
    logic [15:0] exp_stall;

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("in_reset");
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check_idle("post_reset");
        check_eq("post_reset_stall", 32'(stall_cnt), 32'd0);

        // Full frame with valid held high
        run_frame(0, ncyc, nline, nwin, ndone, stall_done, ok);
        check_eq("full_done_seen", 32'(ok), 32'd1);
        check_eq("full_cycles", 32'(ncyc), 32'd23);
        check_eq("full_line_end", 32'(nline), 32'd4);
        check_eq("full_win_end", 32'(nwin), 32'd2);
        check_eq("full_frame_done", 32'(ndone), 32'd1);
        check_eq("full_stall", 32'(stall_done), 32'd0);
        check_idle("full_after");

        // Valid toggling: 16 stall cycles stretch the frame to 39
        run_frame(1, ncyc, nline, nwin, ndone, stall_done, ok);
`ifdef WINDOW_SCAN_STALL_CNT_EN
        exp_stall = 16'd16;
`else
        exp_stall = 16'd0;
`endif
        check_eq("tog_cycles", 32'(ncyc), 32'd39);
        check_eq("tog_line_end", 32'(nline), 32'd4);
        check_eq("tog_stall", 32'(stall_done), 32'(exp_stall));
        check_idle("tog_after");

        // Count_data holds across a stall cycle
        start = 1'b1; @(negedge clk); start = 1'b0;
        in_valid = 1'b1; @(negedge clk);
        check_eq("hold_adv", 32'(count_data), 32'd1);
        in_valid = 1'b0; @(negedge clk);
        check_eq("hold_stall", 32'(count_data), 32'd1);
        check_eq("hold_state", 32'(state), 32'd1);
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        check_idle("hold_abort");

        // Abort at count_line=1, count_data=2 with a beat presented
        start = 1'b1; @(negedge clk); start = 1'b0;
        in_valid = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            if (state == 3'd1 && count_line == 1'b1 && count_data == 2'd2) found = 1'b1;
            else @(negedge clk);
        end
        check_eq("abort_point_found", 32'(found), 32'd1);
        abort = 1'b1; @(negedge clk); abort = 1'b0; in_valid = 1'b0;
        check_idle("abort_next");
        run_frame(0, ncyc, nline, nwin, ndone, stall_done, ok);
        check_eq("abort_restart_cycles", 32'(ncyc), 32'd23);

        // Start during DATA and LINE is ignored
        run_frame(2, ncyc, nline, nwin, ndone, stall_done, ok);
        check_eq("start_ign_cycles", 32'(ncyc), 32'd23);
        check_eq("start_ign_line_end", 32'(nline), 32'd4);
        check_eq("start_ign_win_end", 32'(nwin), 32'd2);
        check_idle("start_ign_after");

        // Asynchronous reset in the middle of a WIN cycle
        start = 1'b1; @(negedge clk); start = 1'b0;
        in_valid = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            if (state == 3'd3) found = 1'b1;
            else @(negedge clk);
        end
        check_eq("win_found", 32'(found), 32'd1);
        check_eq("win_strobe", 32'(win_end), 32'd1);
        #2 reset = 1'b1;
        #1 check_idle("async_reset");
        check_eq("async_reset_stall", 32'(stall_cnt), 32'd0);
        #1 reset = 1'b0;
        repeat (5) @(negedge clk);
        check_idle("no_restart");
        in_valid = 1'b0;
        run_frame(0, ncyc, nline, nwin, ndone, stall_done, ok);
        check_eq("reset_restart_cycles", 32'(ncyc), 32'd23);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
